frame_bank_scheduler: RTL and testbench

Schedules the four DDR2 frame banks between the video write path and a downstream frame reader, entirely in the vin_clk domain. On each frame sync it decides whether the frame just written is complete and publishes it to the reader. It then picks the next write bank, which drives the writer's 2-bit frame address. A reader lock handshake guarantees the writer never overwrites the bank being read.

---
 rtl/frame_bank_pkg.sv | 16 +
 rtl/frame_bank_pick.sv | 37 +++
 rtl/frame_bank_scheduler.sv | 175 +++++++++++++++++
 tb/tb_frame_bank_scheduler.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/frame_bank_pkg.sv
// frame_bank_pkg: shared constants and types for the frame bank scheduler.
// Holds the bank count/width, the capture FSM state encoding and the widths
// of the line and timeout counters.
package frame_bank_pkg;

  localparam int NUM_BANKS = 4;
  localparam int BANK_W    = 2;
  localparam int LINE_W    = 12;
  localparam int TMO_W     = 24;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    CAPTURE = 1'b1
  } state_t;

endpackage

// File: rtl/frame_bank_pick.sv
// frame_bank_pick: combinational choice of the next write bank.
// Ports: cur_bank_i (bank being written), latest_bank_i/latest_vld_i (newest
// complete frame), lock_bank_i/lock_vld_i (bank held by the reader); next_bank_o.
module frame_bank_pick
  import frame_bank_pkg::*;
(
  input  logic [BANK_W-1:0] cur_bank_i,
  input  logic [BANK_W-1:0] latest_bank_i,
  input  logic              latest_vld_i,
  input  logic [BANK_W-1:0] lock_bank_i,
  input  logic              lock_vld_i,
  output logic [BANK_W-1:0] next_bank_o
);

  logic [BANK_W-1:0] cand;
  logic              found;
  logic              excluded;

  // Walk forward from the current bank; the 4th candidate wraps back onto the
  // current bank. With at most two exclusions, one of the four always wins.
  always_comb begin
    next_bank_o = cur_bank_i + 1'b1;
    found       = 1'b0;
    cand        = '0;
    excluded    = 1'b0;
    for (int i = 1; i <= NUM_BANKS; i++) begin
      cand     = cur_bank_i + BANK_W'(i);
      excluded = (latest_vld_i && (cand == latest_bank_i)) ||
                 (lock_vld_i   && (cand == lock_bank_i));
      if (!found && !excluded) begin
        next_bank_o = cand;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_bank_scheduler.sv
// frame_bank_scheduler: rotates four DDR2 frame banks between the video writer
// and a frame reader, publishing complete frames and honouring a reader lock.
// Ports: vin_vs/vin_de/cfg_height in; wr_bank/wr_frame_start to the writer;
// rd_lock_req/rd_lock_ack/rd_bank/rd_bank_valid to the reader; drop_cnt status.
module frame_bank_scheduler
  import frame_bank_pkg::*;
#(
  parameter logic [TMO_W-1:0] TIMEOUT_CYC = 24'd8_000_000,
  parameter int               DROP_W      = 16
) (
  input  logic              rst_n,
  input  logic              vin_clk,
  input  logic              vin_vs,
  input  logic              vin_de,
  input  logic [LINE_W-1:0] cfg_height,
  output logic [BANK_W-1:0] wr_bank,
  output logic              wr_frame_start,
  input  logic              rd_lock_req,
  output logic              rd_lock_ack,
  output logic [BANK_W-1:0] rd_bank,
  output logic              rd_bank_valid,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam logic [TMO_W-1:0] TMO_LAST = TIMEOUT_CYC - TMO_W'(1);

  state_t              state_q, state_d;
  logic                vs_s_q, vs_dly_q;
  logic                de_s_q, de_dly_q;
  logic [LINE_W-1:0]   line_cnt_q, line_cnt_d;
  logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic [BANK_W-1:0]   wr_bank_q, wr_bank_d;
  logic                wr_start_q, wr_start_d;
  logic [BANK_W-1:0]   latest_q, latest_d;
  logic                latest_vld_q, latest_vld_d;
  logic [BANK_W-1:0]   lock_bank_q, lock_bank_d;
  logic                ack_q, ack_d;
  logic [BANK_W-1:0]   rd_bank_q, rd_bank_d;
  logic [DROP_W-1:0]   drop_q, drop_d;

  logic                vs_rise, de_fall;
  logic [LINE_W-1:0]   line_now;
  logic                new_frame, commit, drop_evt;
  logic [BANK_W-1:0]   pick_bank;

  // The sync inputs are registered once, then delayed once more for edge
  // detection, so a vs first seen at edge k acts at edge k+1.
  assign vs_rise = vs_s_q & ~vs_dly_q;
  assign de_fall = ~de_s_q & de_dly_q;

  // A line ending in the same cycle as vs still belongs to the ending frame.
  always_comb begin
    line_now = line_cnt_q;
    if (de_fall && (line_cnt_q != '1)) line_now = line_cnt_q + 1'b1;
  end

  // Capture FSM: frame boundaries, line counting and source-loss timeout.
  always_comb begin
    state_d    = state_q;
    line_cnt_d = line_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    new_frame  = 1'b0;
    commit     = 1'b0;
    drop_evt   = 1'b0;
    case (state_q)
      IDLE: begin
        tmo_cnt_d = '0;
        if (vs_rise) begin
          new_frame = 1'b1;
          state_d   = CAPTURE;
        end
      end
      CAPTURE: begin
        line_cnt_d = line_now;
        if (vs_rise) begin
          tmo_cnt_d = '0;
          new_frame = 1'b1;
          if ((line_now == cfg_height) && (cfg_height != '0)) commit = 1'b1;
          else drop_evt = 1'b1;
        end else if (tmo_cnt_q == TMO_LAST) begin
          tmo_cnt_d = '0;
          drop_evt  = 1'b1;
          state_d   = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (new_frame) line_cnt_d = '0;
  end

  // Published frame, reader lock and drop counter. The lock samples the
  // registered latest, so a request arriving with a commit gets the old frame.
  always_comb begin
    latest_d     = latest_q;
    latest_vld_d = latest_vld_q;
    lock_bank_d  = lock_bank_q;
    ack_d        = ack_q;
    drop_d       = drop_q;
    if (commit) begin
      latest_d     = wr_bank_q;
      latest_vld_d = 1'b1;
    end
    if (drop_evt && (drop_q != '1)) drop_d = drop_q + 1'b1;
    if (!rd_lock_req) begin
      ack_d       = 1'b0;
      lock_bank_d = '0;
    end else if (!ack_q && latest_vld_q) begin
      ack_d       = 1'b1;
      lock_bank_d = latest_q;
    end
    rd_bank_d = ack_d ? lock_bank_d : latest_d;
  end

  // Exclusions use next-cycle latest/lock so a same-cycle commit or lock is
  // never handed to the writer.
  frame_bank_pick u_pick (
    .cur_bank_i    (wr_bank_q),
    .latest_bank_i (latest_d),
    .latest_vld_i  (latest_vld_d),
    .lock_bank_i   (lock_bank_d),
    .lock_vld_i    (ack_d),
    .next_bank_o   (pick_bank)
  );

  always_comb begin
    wr_bank_d  = new_frame ? pick_bank : wr_bank_q;
    wr_start_d = new_frame;
  end

  always_ff @(posedge vin_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      vs_s_q       <= 1'b0;
      vs_dly_q     <= 1'b0;
      de_s_q       <= 1'b0;
      de_dly_q     <= 1'b0;
      line_cnt_q   <= '0;
      tmo_cnt_q    <= '0;
      wr_bank_q    <= '0;
      wr_start_q   <= 1'b0;
      latest_q     <= '0;
      latest_vld_q <= 1'b0;
      lock_bank_q  <= '0;
      ack_q        <= 1'b0;
      rd_bank_q    <= '0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      vs_s_q       <= vin_vs;
      vs_dly_q     <= vs_s_q;
      de_s_q       <= vin_de;
      de_dly_q     <= de_s_q;
      line_cnt_q   <= line_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      wr_bank_q    <= wr_bank_d;
      wr_start_q   <= wr_start_d;
      latest_q     <= latest_d;
      latest_vld_q <= latest_vld_d;
      lock_bank_q  <= lock_bank_d;
      ack_q        <= ack_d;
      rd_bank_q    <= rd_bank_d;
      drop_q       <= drop_d;
    end
  end

  assign wr_bank        = wr_bank_q;
  assign wr_frame_start = wr_start_q;
  assign rd_lock_ack    = ack_q;
  assign rd_bank        = rd_bank_q;
  assign rd_bank_valid  = latest_vld_q;
  assign drop_cnt       = drop_q;

endmodule

// File: tb/tb_frame_bank_scheduler.sv
// tb_frame_bank_scheduler: scoreboard bench for frame_bank_scheduler.
// Each vs pushes the expected writer/reader state for the following
// wr_frame_start pulse; a negedge monitor pops and compares it.
module tb_frame_bank_scheduler;

  logic        rst_n;
  logic        vin_clk;
  logic        vin_vs;
  logic        vin_de;
  logic [11:0] cfg_height;
  logic [1:0]  wr_bank;
  logic        wr_frame_start;
  logic        rd_lock_req;
  logic        rd_lock_ack;
  logic [1:0]  rd_bank;
  logic        rd_bank_valid;
  logic [15:0] drop_cnt;

  typedef struct {
    logic [1:0]  wr;
    logic [1:0]  rd;
    logic        vld;
    logic [15:0] drop;
    logic        ack;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  frame_bank_scheduler #(
    .TIMEOUT_CYC (24'd100),
    .DROP_W      (16)
  ) dut (
    .rst_n          (rst_n),
    .vin_clk        (vin_clk),
    .vin_vs         (vin_vs),
    .vin_de         (vin_de),
    .cfg_height     (cfg_height),
    .wr_bank        (wr_bank),
    .wr_frame_start (wr_frame_start),
    .rd_lock_req    (rd_lock_req),
    .rd_lock_ack    (rd_lock_ack),
    .rd_bank        (rd_bank),
    .rd_bank_valid  (rd_bank_valid),
    .drop_cnt       (drop_cnt)
  );

  initial vin_clk = 1'b0;
  always #5 vin_clk = ~vin_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard side: every frame-start pulse must match a queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge vin_clk);
      if (rst_n && wr_frame_start) begin
        if (exp_q.size() == 0) begin
          check("spurious_start", 32'(wr_frame_start), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("sb_wr_bank", 32'(wr_bank), 32'(e.wr));
          check("sb_rd_bank", 32'(rd_bank), 32'(e.rd));
          check("sb_rd_valid", 32'(rd_bank_valid), 32'(e.vld));
          check("sb_drop", 32'(drop_cnt), 32'(e.drop));
          check("sb_ack", 32'(rd_lock_ack), 32'(e.ack));
        end
      end
    end
  end

  task automatic tick();
    @(posedge vin_clk);
    #1;
  endtask

  task automatic do_reset();
    vin_vs      = 1'b0;
    vin_de      = 1'b0;
    rd_lock_req = 1'b0;
    rst_n       = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_bank"}, 32'(wr_bank), 32'd0);
    check({tag, "_start"}, 32'(wr_frame_start), 32'd0);
    check({tag, "_ack"}, 32'(rd_lock_ack), 32'd0);
    check({tag, "_rd_bank"}, 32'(rd_bank), 32'd0);
    check({tag, "_rd_valid"}, 32'(rd_bank_valid), 32'd0);
    check({tag, "_drop"}, 32'(drop_cnt), 32'd0);
  endtask

  // Frame sync with the expected state at the resulting frame-start pulse.
  task automatic vs_frame(input logic [1:0] wr, input logic [1:0] rd, input logic vld,
                          input logic [15:0] drop, input logic ack, input bit req_at_commit);
    exp_t e;
    e.wr = wr; e.rd = rd; e.vld = vld; e.drop = drop; e.ack = ack;
    exp_q.push_back(e);
    vin_vs = 1'b1;
    tick();
    if (req_at_commit) rd_lock_req = 1'b1;
    tick();
    vin_vs = 1'b0;
    repeat (2) tick();
  endtask

  task automatic lines(input int n);
    for (int i = 0; i < n; i++) begin
      vin_de = 1'b1;
      repeat (4) tick();
      vin_de = 1'b0;
      repeat (2) tick();
    end
  endtask

  initial begin
    cfg_height = 12'd4;

    // Four good frames: banks rotate and each frame is published.
    do_reset();
    check_reset_outputs("rst1");
    vs_frame(2'd1, 2'd0, 1'b0, 16'd0, 1'b0, 0);
    lines(4);
    vs_frame(2'd2, 2'd1, 1'b1, 16'd0, 1'b0, 0);
    lines(4);
    vs_frame(2'd3, 2'd2, 1'b1, 16'd0, 1'b0, 0);
    lines(4);
    vs_frame(2'd0, 2'd3, 1'b1, 16'd0, 1'b0, 0);

    // Short then long frame: both dropped, nothing published.
    do_reset();
    vs_frame(2'd1, 2'd0, 1'b0, 16'd0, 1'b0, 0);
    lines(3);
    vs_frame(2'd2, 2'd0, 1'b0, 16'd1, 1'b0, 0);
    lines(5);
    vs_frame(2'd3, 2'd0, 1'b0, 16'd2, 1'b0, 0);

    // Lock bank 1, then six good frames never touch bank 1.
    do_reset();
    vs_frame(2'd1, 2'd0, 1'b0, 16'd0, 1'b0, 0);
    lines(4);
    vs_frame(2'd2, 2'd1, 1'b1, 16'd0, 1'b0, 0);
    rd_lock_req = 1'b1;
    check("lock_pre_ack", 32'(rd_lock_ack), 32'd0);
    tick();
    check("lock_ack", 32'(rd_lock_ack), 32'd1);
    check("lock_rd_bank", 32'(rd_bank), 32'd1);
    lines(4); vs_frame(2'd3, 2'd1, 1'b1, 16'd0, 1'b1, 0);
    lines(4); vs_frame(2'd0, 2'd1, 1'b1, 16'd0, 1'b1, 0);
    lines(4); vs_frame(2'd2, 2'd1, 1'b1, 16'd0, 1'b1, 0);
    lines(4); vs_frame(2'd3, 2'd1, 1'b1, 16'd0, 1'b1, 0);
    lines(4); vs_frame(2'd0, 2'd1, 1'b1, 16'd0, 1'b1, 0);
    lines(4); vs_frame(2'd2, 2'd1, 1'b1, 16'd0, 1'b1, 0);
    rd_lock_req = 1'b0;
    check("rel_ack_held", 32'(rd_lock_ack), 32'd1);
    tick();
    check("rel_ack", 32'(rd_lock_ack), 32'd0);
    check("rel_rd_bank", 32'(rd_bank), 32'd0);

    // Lock request arrives with the commit of bank 2: lock takes bank 1.
    do_reset();
    vs_frame(2'd1, 2'd0, 1'b0, 16'd0, 1'b0, 0);
    lines(4);
    vs_frame(2'd2, 2'd1, 1'b1, 16'd0, 1'b0, 0);
    lines(4);
    vs_frame(2'd3, 2'd1, 1'b1, 16'd0, 1'b1, 1);
    check("race_ack", 32'(rd_lock_ack), 32'd1);
    lines(4);
    vs_frame(2'd0, 2'd1, 1'b1, 16'd0, 1'b1, 0);
    rd_lock_req = 1'b0;
    tick();

    // Source lost mid-frame: one drop after the timeout, published frame kept.
    do_reset();
    vs_frame(2'd1, 2'd0, 1'b0, 16'd0, 1'b0, 0);
    lines(4);
    vs_frame(2'd2, 2'd1, 1'b1, 16'd0, 1'b0, 0);
    lines(2);
    repeat (80) tick();
    check("tmo_before", 32'(drop_cnt), 32'd0);
    repeat (10) tick();
    check("tmo_drop", 32'(drop_cnt), 32'd1);
    check("tmo_rd_valid", 32'(rd_bank_valid), 32'd1);
    check("tmo_rd_bank", 32'(rd_bank), 32'd1);
    vs_frame(2'd3, 2'd1, 1'b1, 16'd1, 1'b0, 0);
    lines(4);
    vs_frame(2'd0, 2'd3, 1'b1, 16'd1, 1'b0, 0);

    // Asynchronous reset mid-frame while locked; request stays high after.
    do_reset();
    vs_frame(2'd1, 2'd0, 1'b0, 16'd0, 1'b0, 0);
    lines(4);
    vs_frame(2'd2, 2'd1, 1'b1, 16'd0, 1'b0, 0);
    rd_lock_req = 1'b1;
    tick();
    check("pre_rst_ack", 32'(rd_lock_ack), 32'd1);
    lines(2);
    @(posedge vin_clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("arst");
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("post_rst_ack", 32'(rd_lock_ack), 32'd0);
    vs_frame(2'd1, 2'd0, 1'b0, 16'd0, 1'b0, 0);
    lines(4);
    check("post_rst_ack2", 32'(rd_lock_ack), 32'd0);
    vs_frame(2'd2, 2'd1, 1'b1, 16'd0, 1'b0, 0);
    check("post_commit_ack", 32'(rd_lock_ack), 32'd1);
    check("post_commit_rd", 32'(rd_bank), 32'd1);
    rd_lock_req = 1'b0;
    repeat (2) tick();

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
